// File: rtl/cceip_kernel_pkg.sv
// Shared types and helpers for the cceip kernel output path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: writer FSM state enum, beat/record sizes, 8-bit popcount.
package cceip_kernel_pkg;

    // Bytes carried by one 64-bit stream beat.
    localparam int BEAT_BYTES        = 8;
    // The length record is a single 64-bit word.
    localparam int SIZE_RECORD_BYTES = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DATA_LAUNCH,
        S_DATA_STREAM,
        S_DATA_DRAIN,
        S_DATA_PAD,
        S_DATA_WAIT,
        S_SIZE_LAUNCH,
        S_SIZE_BEAT,
        S_SIZE_WAIT,
        S_DONE
    } writer_state_t;

    // Number of valid bytes flagged by a tkeep mask.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cceip_output_writer.sv
// Writes the cceip output stream to a fixed-capacity buffer, then an 8-byte length record.
// Latency: data path is a zero-cycle pass-through while streaming; control is registered.
// Backpressure: s_tready follows wm_tready while streaming; overflow beats are sunk unconditionally.
//
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   start, out_addr, size_addr,
//   max_bytes                   job request and arguments (sampled only when idle)
//   busy, done, overflow,
//   out_bytes                   job status; out_bytes/overflow hold until the next start
//   s_t*                        64-bit input stream with byte keep and last
//   wm_start/addr/size/done     write-master command and completion
//   wm_tvalid/tready/tdata      write-master data stream
module cceip_output_writer
    import cceip_kernel_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 64
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         start,
    input  logic [C_ADDR_WIDTH-1:0]      out_addr,
    input  logic [C_ADDR_WIDTH-1:0]      size_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] max_bytes,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [C_XFER_SIZE_WIDTH-1:0] out_bytes,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [63:0]                  s_tdata,
    input  logic [7:0]                   s_tkeep,
    input  logic                         s_tlast,
    output logic                         wm_start,
    output logic [C_ADDR_WIDTH-1:0]      wm_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0] wm_size,
    input  logic                         wm_done,
    output logic                         wm_tvalid,
    input  logic                         wm_tready,
    output logic [63:0]                  wm_tdata
);

    localparam int XW         = C_XFER_SIZE_WIDTH;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    writer_state_t           state;
    logic [C_ADDR_WIDTH-1:0] size_addr_q;
    logic [XW-1:0]           cap_q;
    logic [XW-1:0]           byte_cnt;
    logic [XW-1:0]           beats_left;

    logic [XW-1:0]           cap_in;
    logic [XW-1:0]           beats_in;
    logic                    last_slot;
    logic                    data_acc;
    logic [63:0]             kept_dat;

    // Capacity is whole beats only; a partial trailing beat is never written.
    assign cap_in    = max_bytes & ~XW'(BEAT_BYTES - 1);
    assign beats_in  = max_bytes >> BEAT_SHIFT;
    assign last_slot = (beats_left == XW'(1));
    assign data_acc  = s_tvalid && wm_tready;
    assign busy      = (state != S_IDLE);

    // Bytes outside tkeep are zeroed so stale bus contents never reach memory.
    always_comb begin
        kept_dat = 64'd0;
        for (int i = 0; i < 8; i++) begin
            kept_dat[8*i +: 8] = s_tkeep[i] ? s_tdata[8*i +: 8] : 8'h00;
        end
    end

    // Stream-side handshakes are combinational so streaming adds no bubble.
    always_comb begin
        s_tready  = 1'b0;
        wm_tvalid = 1'b0;
        wm_tdata  = 64'd0;
        case (state)
            S_DATA_STREAM: begin
                s_tready  = wm_tready;
                wm_tvalid = s_tvalid;
                wm_tdata  = kept_dat;
            end
            S_DATA_PAD: begin
                wm_tvalid = 1'b1;
            end
            S_DATA_DRAIN: begin
                s_tready = 1'b1;
            end
            S_SIZE_BEAT: begin
                wm_tvalid = 1'b1;
                wm_tdata  = 64'(byte_cnt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            size_addr_q <= '0;
            cap_q       <= '0;
            byte_cnt    <= '0;
            beats_left  <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            out_bytes   <= '0;
            wm_start    <= 1'b0;
            wm_addr     <= '0;
            wm_size     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_addr_q <= size_addr;
                        cap_q       <= cap_in;
                        byte_cnt    <= '0;
                        beats_left  <= beats_in;
                        overflow    <= 1'b0;
                        out_bytes   <= '0;
                        if (cap_in != '0) begin
                            // wm_addr/wm_size are loaded with the launch and held
                            // untouched until the size launch, which keeps them
                            // stable across the whole data transfer.
                            wm_start <= 1'b1;
                            wm_addr  <= out_addr;
                            wm_size  <= cap_in;
                            state    <= S_DATA_LAUNCH;
                        end else begin
                            // No room at all: everything is overflow.
                            state <= S_DATA_DRAIN;
                        end
                    end
                end

                S_DATA_LAUNCH: begin
                    wm_start <= 1'b0;
                    state    <= S_DATA_STREAM;
                end

                S_DATA_STREAM: begin
                    if (data_acc) begin
                        byte_cnt   <= byte_cnt + XW'(popcount8(s_tkeep));
                        beats_left <= beats_left - XW'(1);
                        if (s_tlast) begin
                            state <= last_slot ? S_DATA_WAIT : S_DATA_PAD;
                        end else if (last_slot) begin
                            state <= S_DATA_DRAIN;
                        end
                    end
                end

                // The write master was told cap bytes, so short jobs are
                // filled out with zero beats.
                S_DATA_PAD: begin
                    if (wm_tready) begin
                        beats_left <= beats_left - XW'(1);
                        if (last_slot) begin
                            state <= S_DATA_WAIT;
                        end
                    end
                end

                S_DATA_DRAIN: begin
                    if (s_tvalid) begin
                        overflow <= 1'b1;
                        if (s_tlast) begin
                            if (cap_q != '0) begin
                                state <= S_DATA_WAIT;
                            end else begin
                                wm_start <= 1'b1;
                                wm_addr  <= size_addr_q;
                                wm_size  <= XW'(SIZE_RECORD_BYTES);
                                state    <= S_SIZE_LAUNCH;
                            end
                        end
                    end
                end

                S_DATA_WAIT: begin
                    if (wm_done) begin
                        wm_start <= 1'b1;
                        wm_addr  <= size_addr_q;
                        wm_size  <= XW'(SIZE_RECORD_BYTES);
                        state    <= S_SIZE_LAUNCH;
                    end
                end

                S_SIZE_LAUNCH: begin
                    wm_start <= 1'b0;
                    state    <= S_SIZE_BEAT;
                end

                S_SIZE_BEAT: begin
                    if (wm_tready) begin
                        state <= S_SIZE_WAIT;
                    end
                end

                S_SIZE_WAIT: begin
                    if (wm_done) begin
                        done      <= 1'b1;
                        out_bytes <= byte_cnt;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cceip_output_writer.sv
// Directed bench for cceip_output_writer with a behavioural write master.
// Latency: n/a (bench).
// Backpressure: the write master can randomly stall wm_tready; the source can insert gaps.
module tb_cceip_output_writer;

    localparam logic [63:0] OUT_A  = 64'h0000_0000_0000_1000;
    localparam logic [63:0] SIZE_A = 64'h0000_0000_0000_2000;
    localparam int          DONE_LAT = 12;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        start;
    logic [63:0] out_addr;
    logic [63:0] size_addr;
    logic [63:0] max_bytes;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [63:0] out_bytes;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        wm_start;
    logic [63:0] wm_addr;
    logic [63:0] wm_size;
    logic        wm_done;
    logic        wm_tvalid;
    logic        wm_tready;
    logic [63:0] wm_tdata;

    cceip_output_writer #(
        .C_ADDR_WIDTH      (64),
        .C_XFER_SIZE_WIDTH (64)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .start     (start),
        .out_addr  (out_addr),
        .size_addr (size_addr),
        .max_bytes (max_bytes),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .out_bytes (out_bytes),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .wm_start  (wm_start),
        .wm_addr   (wm_addr),
        .wm_size   (wm_size),
        .wm_done   (wm_done),
        .wm_tvalid (wm_tvalid),
        .wm_tready (wm_tready),
        .wm_tdata  (wm_tdata)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // Write-master model state.
    logic [63:0] dq[$];
    int          n_data_starts;
    int          n_size_starts;
    logic [63:0] size_val;
    logic [63:0] data_size_seen;
    logic [63:0] data_addr_seen;
    int          stab_err;
    int          stray;
    logic        m_active;
    logic [63:0] m_addr;
    logic [63:0] m_size;
    int          m_exp;
    int          m_got;
    int          done_cnt;
    logic        done_pend;
    logic        stall;
    int          send_to;

    initial begin
        m_active  = 1'b0;
        done_cnt  = 0;
        done_pend = 1'b0;
        stall     = 1'b0;
        wm_done   = 1'b0;
        wm_tready = 1'b1;
    end

    // Observe the DUT mid-cycle; handshakes seen here complete at the next rising edge.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            m_active  = 1'b0;
            done_cnt  = 0;
            done_pend = 1'b0;
        end else begin
            if (m_active && (wm_addr !== m_addr || wm_size !== m_size)) stab_err++;
            if (wm_tvalid && wm_tready) begin
                if (!m_active) begin
                    stray++;
                end else begin
                    if (m_addr == SIZE_A) size_val = wm_tdata;
                    else dq.push_back(wm_tdata);
                    m_got++;
                    if (m_got == m_exp) done_cnt = DONE_LAT;
                end
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) done_pend = 1'b1;
            end
            if (wm_done) m_active = 1'b0;
            if (wm_start) begin
                m_active = 1'b1;
                m_addr   = wm_addr;
                m_size   = wm_size;
                m_exp    = int'(wm_size >> 3);
                m_got    = 0;
                if (wm_addr == SIZE_A) begin
                    n_size_starts++;
                end else begin
                    n_data_starts++;
                    data_size_seen = wm_size;
                    data_addr_seen = wm_addr;
                end
            end
        end
    end

    always @(posedge ap_clk) begin
        #1;
        wm_done   = done_pend;
        done_pend = 1'b0;
        wm_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        dq.delete();
        n_data_starts  = 0;
        n_size_starts  = 0;
        size_val       = 64'hDEAD_BEEF_DEAD_BEEF;
        data_size_seen = 64'd0;
        data_addr_seen = 64'd0;
        stab_err       = 0;
        stray          = 0;
        send_to        = 0;
    endtask

    // All stimulus tasks begin and end 1 time unit after a rising edge.
    task automatic start_job(input logic [63:0] mb);
        clear_model();
        max_bytes = mb;
        start     = 1'b1;
        @(posedge ap_clk); #1;
        start     = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input int gap);
        logic acc;
        int   n;
        s_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge ap_clk); #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 300) begin
            @(negedge ap_clk);
            acc = s_tready;
            @(posedge ap_clk); #1;
            n++;
        end
        if (!acc) send_to++;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done(output logic got, output logic [63:0] ob, output logic ov);
        got = 1'b0;
        ob  = 64'd0;
        ov  = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge ap_clk);
            if (done) begin
                got = 1'b1;
                ob  = out_bytes;
                ov  = overflow;
            end
        end
        @(posedge ap_clk); #1;
    endtask

    logic        got;
    logic [63:0] ob;
    logic        ov;
    logic [63:0] pat;
    logic [63:0] acc_or;
    int          mism;

    initial begin
        ap_rst_n  = 1'b0;
        start     = 1'b0;
        out_addr  = OUT_A;
        size_addr = SIZE_A;
        max_bytes = 64'd0;
        s_tvalid  = 1'b0;
        s_tdata   = 64'd0;
        s_tkeep   = 8'd0;
        s_tlast   = 1'b0;
        clear_model();
        repeat (3) @(posedge ap_clk);
        #1;

        // Reset state.
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_out_bytes", out_bytes, 64'd0);
        check("rst_s_tready", {63'd0, s_tready}, 64'd0);
        check("rst_wm_tvalid", {63'd0, wm_tvalid}, 64'd0);
        check("rst_wm_start", {63'd0, wm_start}, 64'd0);
        check("rst_wm_addr", wm_addr, 64'd0);
        check("rst_wm_size", wm_size, 64'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        // Job A: capacity 64 (low bits of 69 dropped), 3 full beats then a half beat.
        start_job(64'd69);
        check("a_busy", {63'd0, busy}, 64'd1);
        send(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 0);
        // A start while busy must be ignored.
        max_bytes = 64'd8;
        start = 1'b1;
        @(posedge ap_clk); #1;
        start = 1'b0;
        send(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 0);
        send(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b0, 1);
        send(64'hDDDD_EEEE_FFFF_0123, 8'h0F, 1'b1, 0);
        wait_done(got, ob, ov);
        check("a_done_seen", {63'd0, got}, 64'd1);
        check("a_out_bytes", ob, 64'd28);
        check("a_overflow", {63'd0, ov}, 64'd0);
        check("a_done_pulse_width", {63'd0, done}, 64'd0);
        check("a_idle_after", {63'd0, busy}, 64'd0);
        check("a_out_bytes_hold", out_bytes, 64'd28);
        check("a_data_starts", 64'(n_data_starts), 64'd1);
        check("a_data_addr", data_addr_seen, OUT_A);
        check("a_data_size", data_size_seen, 64'd64);
        check("a_beats", 64'(dq.size()), 64'd8);
        check("a_beat0", dq[0], 64'h1111_2222_3333_4444);
        check("a_beat3_masked", dq[3], 64'h0000_0000_FFFF_0123);
        acc_or = 64'd0;
        for (int i = 4; i < 8; i++) acc_or = acc_or | dq[i];
        check("a_pad_zero", acc_or, 64'd0);
        check("a_size_starts", 64'(n_size_starts), 64'd1);
        check("a_size_record", size_val, 64'd28);
        check("a_stable", 64'(stab_err), 64'd0);
        check("a_stray", 64'(stray), 64'd0);
        check("a_send_timeouts", 64'(send_to), 64'd0);

        // Job B: capacity 16, five beats -> two written, three drained.
        start_job(64'd16);
        for (int i = 0; i < 5; i++) begin
            pat = 64'h0B0B_0000_0000_0000 | 64'(i);
            send(pat, 8'hFF, (i == 4), 0);
        end
        wait_done(got, ob, ov);
        check("b_done_seen", {63'd0, got}, 64'd1);
        check("b_out_bytes", ob, 64'd16);
        check("b_overflow", {63'd0, ov}, 64'd1);
        check("b_beats", 64'(dq.size()), 64'd2);
        check("b_beat1", dq[1], 64'h0B0B_0000_0000_0001);
        check("b_size_record", size_val, 64'd16);
        check("b_overflow_hold", {63'd0, overflow}, 64'd1);
        check("b_send_timeouts", 64'(send_to), 64'd0);

        // Job C: zero capacity -> no data launch, size record 0, overflow.
        start_job(64'd7);
        send(64'hC0C0_C0C0_C0C0_C0C0, 8'hFF, 1'b1, 0);
        wait_done(got, ob, ov);
        check("c_done_seen", {63'd0, got}, 64'd1);
        check("c_data_starts", 64'(n_data_starts), 64'd0);
        check("c_size_starts", 64'(n_size_starts), 64'd1);
        check("c_size_record", size_val, 64'd0);
        check("c_overflow", {63'd0, ov}, 64'd1);
        check("c_out_bytes", ob, 64'd0);
        check("c_stray", 64'(stray), 64'd0);

        // Job D: 1024 bytes with random source gaps and write-master stalls.
        stall = 1'b1;
        start_job(64'd1024);
        for (int i = 0; i < 128; i++) begin
            pat = 64'hA5A5_0000_0000_0000 ^ 64'(i);
            send(pat, 8'hFF, (i == 127), int'($urandom_range(0, 2)));
        end
        wait_done(got, ob, ov);
        stall = 1'b0;
        mism = 0;
        for (int i = 0; i < 128; i++) begin
            pat = 64'hA5A5_0000_0000_0000 ^ 64'(i);
            if (dq[i] !== pat) mism++;
        end
        check("d_done_seen", {63'd0, got}, 64'd1);
        check("d_out_bytes", ob, 64'd1024);
        check("d_overflow", {63'd0, ov}, 64'd0);
        check("d_beats", 64'(dq.size()), 64'd128);
        check("d_data", 64'(mism), 64'd0);
        check("d_size_record", size_val, 64'd1024);
        check("d_stable", 64'(stab_err), 64'd0);
        check("d_send_timeouts", 64'(send_to), 64'd0);

        // Job E: reset while padding, then a normal job.
        start_job(64'd64);
        send(64'hE0E0_E0E0_E0E0_E0E0, 8'hFF, 1'b1, 0);
        check("e_pad_valid", {63'd0, wm_tvalid}, 64'd1);
        check("e_pad_data", wm_tdata, 64'd0);
        check("e_pad_s_tready", {63'd0, s_tready}, 64'd0);
        ap_rst_n = 1'b0;
        #1;
        check("e_rst_busy", {63'd0, busy}, 64'd0);
        check("e_rst_wm_tvalid", {63'd0, wm_tvalid}, 64'd0);
        check("e_rst_wm_tdata", wm_tdata, 64'd0);
        check("e_rst_wm_start", {63'd0, wm_start}, 64'd0);
        check("e_rst_wm_addr", wm_addr, 64'd0);
        check("e_rst_wm_size", wm_size, 64'd0);
        check("e_rst_done", {63'd0, done}, 64'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        start_job(64'd8);
        send(64'h0123_4567_89AB_CDEF, 8'h03, 1'b1, 0);
        wait_done(got, ob, ov);
        check("e_done_seen", {63'd0, got}, 64'd1);
        check("e_out_bytes", ob, 64'd2);
        check("e_overflow", {63'd0, ov}, 64'd0);
        check("e_beats", 64'(dq.size()), 64'd1);
        check("e_beat0", dq[0], 64'h0000_0000_0000_CDEF);
        check("e_size_record", size_val, 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
